add64_ovf: RTL and testbench

//   Signed two's-complement adder with overflow flag for the Y86-64 ALU add path (OPq addq).

---
 rtl/add64_ovf.sv | 79 +++++++
 tb/tb_add64_ovf.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/add64_ovf.sv
`default_nettype none
// ============================================================================
//  Module   : add64_ovf
//  Purpose  : Registered signed adder with overflow flag for the Y86-64 ALU
//             addq path; structural ripple-carry chain of gate-level adders.
//  Revision : 1.0  initial release
// ============================================================================

module add64_ovf_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);
endmodule

module add64_ovf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             of
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic             w_of;
    logic [WIDTH-1:0] r_sum;
    logic             r_of;
    logic             r_valid;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        add64_ovf_fa u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (w_c[i]),
            .s  (w_s[i]),
            .co (w_c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    // The final carry w_c[WIDTH] is otherwise unused (no unsigned-carry port).
    assign w_of = w_c[WIDTH] ^ w_c[WIDTH-1];

    // Operands are only sampled under in_valid, so X/Z on idle cycles never
    // reaches the held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_of    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum <= w_s;
                r_of  <= w_of;
            end
        end
    end

    assign sum       = r_sum;
    assign of        = r_of;
    assign out_valid = r_valid;
endmodule

`default_nettype wire

// File: tb/tb_add64_ovf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add64_ovf
//  Purpose  : Self-checking bench for add64_ovf with a queue scoreboard.
//  Revision : 1.0  initial release
// ============================================================================

module tb_add64_ovf;
    localparam int c_width = 64;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [c_width-1:0] x;
    logic [c_width-1:0] y;
    logic               out_valid;
    logic [c_width-1:0] sum;
    logic               of;

    int n_checks;
    int n_errors;

    logic [c_width:0]   sb_q[$];
    logic [c_width-1:0] last_sum;
    logic               last_of;

    add64_ovf #(.WIDTH(c_width)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .sum       (sum),
        .of        (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_width-1:0] got,
                         input logic [c_width-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [c_width:0] model(input logic [c_width-1:0] a,
                                               input logic [c_width-1:0] b);
        logic [c_width-1:0] s;
        logic               o;
        s = a + b;
        o = (a[c_width-1] == b[c_width-1]) && (s[c_width-1] != a[c_width-1]);
        return {o, s};
    endfunction

    // One beat: drive at negedge, push the expectation, check after the edge.
    task automatic step(input logic r, input logic v, input logic [c_width-1:0] a,
                        input logic [c_width-1:0] b, input string tag);
        logic [c_width:0] e;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        if (v) begin
            x = a;
            y = b;
        end else begin
            x = 'x;
            y = 'x;
        end
        if (r && v) sb_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {63'd0, out_valid}, {63'd0, (r && v)});
        if (!r) begin
            sb_q.delete();
            last_sum = '0;
            last_of  = 1'b0;
            check({tag, "_rst_sum"}, sum, '0);
            check({tag, "_rst_of"}, {63'd0, of}, 64'd0);
        end else if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
                e = sb_q.pop_front();
                last_sum = e[c_width-1:0];
                last_of  = e[c_width];
                check({tag, "_sum"}, sum, e[c_width-1:0]);
                check({tag, "_of"}, {63'd0, of}, {63'd0, e[c_width]});
            end
        end else begin
            check({tag, "_hold_sum"}, sum, last_sum);
            check({tag, "_hold_of"}, {63'd0, of}, {63'd0, last_of});
        end
    endtask

    initial begin
        logic [31:0]        r32a;
        logic [31:0]        r32b;
        logic [c_width-1:0] ra;
        logic [c_width-1:0] rb;
        n_checks = 0;
        n_errors = 0;
        last_sum = '0;
        last_of  = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;

        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, "reset");

        step(1'b1, 1'b1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, "pos_neg");
        step(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "max_plus1");
        step(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "min_min");
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "neg1_plus1");
        step(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "min_neg1");

        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0) begin
                r32a = $random;
                r32b = $random;
                ra = {{32{r32a[31]}}, r32a};
                rb = {{32{r32b[31]}}, r32b};
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
            end
            step(1'b1, 1'b1, ra, rb, "rand");
        end

        step(1'b1, 1'b1, 64'd100, 64'd23, "pulse1");
        step(1'b1, 1'b0, 64'd0, 64'd0, "gap");
        step(1'b1, 1'b0, 64'd0, 64'd0, "gap2");
        step(1'b1, 1'b1, 64'h7FFF_0000_0000_0000, 64'h7FFF_0000_0000_0000, "pulse2");
        step(1'b0, 1'b1, 64'd9, 64'd9, "midrst");
        step(1'b1, 1'b0, 64'd0, 64'd0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
